// File: rtl/exe_if.sv
// ID/EXE inputs, MEM/WB forwarding inputs and EXE/MEM outputs of the execute stage.
interface exe_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int ISIZE = 16
);
  logic [DSIZE-1:0] rdata1_in, rdata2_in, imm_in;
  logic [ASIZE-1:0] raddr1_in, raddr2_in, waddr_in;
  logic [ISIZE-1:0] nPC_in;
  logic [2:0]       opcode_in;
  logic             alusrc_in, wen_in, memWrite_in, memRead_in, memtoReg_in, branch_in, jal_in;
  logic             wb_wen;
  logic [ASIZE-1:0] wb_waddr;
  logic [DSIZE-1:0] wb_wdata;
  logic [DSIZE-1:0] alu_result_out, wdata_out;
  logic [ASIZE-1:0] waddr_out;
  logic             wen_out, memWrite_out, memRead_out, memtoReg_out;
  logic             branch_taken_out;
  logic [ISIZE-1:0] branch_target_out;
  logic             stall_out;

  modport master (
    output rdata1_in, rdata2_in, imm_in, raddr1_in, raddr2_in, waddr_in, nPC_in, opcode_in,
           alusrc_in, wen_in, memWrite_in, memRead_in, memtoReg_in, branch_in, jal_in,
           wb_wen, wb_waddr, wb_wdata,
    input  alu_result_out, wdata_out, waddr_out, wen_out, memWrite_out, memRead_out,
           memtoReg_out, branch_taken_out, branch_target_out, stall_out
  );

  modport slave (
    input  rdata1_in, rdata2_in, imm_in, raddr1_in, raddr2_in, waddr_in, nPC_in, opcode_in,
           alusrc_in, wen_in, memWrite_in, memRead_in, memtoReg_in, branch_in, jal_in,
           wb_wen, wb_waddr, wb_wdata,
    output alu_result_out, wdata_out, waddr_out, wen_out, memWrite_out, memRead_out,
           memtoReg_out, branch_taken_out, branch_target_out, stall_out
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: forwarding, single-cycle ALU, iterative shift-add multiply,
// branch/JAL resolution, and the EXE/MEM pipeline register.
module exe_stage #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int ISIZE = 16
) (
  input logic  clk,
  input logic  rst,
  exe_if.slave bus
);
  localparam int SHW = $clog2(DSIZE);
  localparam int CW  = $clog2(DSIZE + 1);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                         OP_SLT = 3'b100, OP_MUL = 3'b101, OP_XOR = 3'b110, OP_SLL = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

  st_t              st_q;
  logic [CW-1:0]    cnt_q;
  logic [DSIZE-1:0] mcand_q, mplier_q, prod_q;
  logic [DSIZE-1:0] res_q, wdata_q;
  logic [ASIZE-1:0] waddr_q;
  logic             wen_q, mw_q, mr_q, mtr_q, tk_q;
  logic [ISIZE-1:0] tgt_q;

  logic [DSIZE-1:0] a, rs2, b, alu, diff, npc_ext;
  logic [ISIZE-1:0] tgt_d;
  logic             tk_d, squash, is_mul;

  // EXE/MEM beats MEM/WB; a load in EXE/MEM has no data yet, so it never forwards.
  always_comb begin
    a = bus.rdata1_in;
    if (wen_q && waddr_q != '0 && waddr_q == bus.raddr1_in && !mr_q)        a = res_q;
    else if (bus.wb_wen && bus.wb_waddr != '0 && bus.wb_waddr == bus.raddr1_in) a = bus.wb_wdata;
    rs2 = bus.rdata2_in;
    if (wen_q && waddr_q != '0 && waddr_q == bus.raddr2_in && !mr_q)        rs2 = res_q;
    else if (bus.wb_wen && bus.wb_waddr != '0 && bus.wb_waddr == bus.raddr2_in) rs2 = bus.wb_wdata;
  end

  assign b    = bus.alusrc_in ? bus.imm_in : rs2;
  assign diff = a - b;

  always_comb begin
    alu = '0;
    case (bus.opcode_in)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = diff;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_SLT:  alu = {{(DSIZE-1){1'b0}}, $signed(a) < $signed(b)};
      OP_XOR:  alu = a ^ b;
      OP_SLL:  alu = a << b[SHW-1:0];
      default: alu = '0;
    endcase
  end

  assign npc_ext   = DSIZE'(bus.nPC_in);
  assign tgt_d     = bus.nPC_in + ISIZE'(bus.imm_in);
  assign tk_d      = (bus.branch_in && diff == '0) || bus.jal_in;
  assign squash    = tk_q;
  assign is_mul    = bus.opcode_in == OP_MUL;
  assign bus.stall_out = (st_q == IDLE && is_mul && !squash) || st_q == BUSY;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= IDLE; cnt_q <= '0;
      mcand_q <= '0; mplier_q <= '0; prod_q <= '0;
      res_q <= '0; wdata_q <= '0; waddr_q <= '0;
      wen_q <= 1'b0; mw_q <= 1'b0; mr_q <= 1'b0; mtr_q <= 1'b0; tk_q <= 1'b0; tgt_q <= '0;
    end else begin
      // Bubble unless a state below captures a real instruction.
      res_q <= '0; wdata_q <= '0; waddr_q <= '0;
      wen_q <= 1'b0; mw_q <= 1'b0; mr_q <= 1'b0; mtr_q <= 1'b0; tk_q <= 1'b0; tgt_q <= '0;
      case (st_q)
        IDLE: if (!squash) begin
          if (is_mul) begin
            mcand_q <= a; mplier_q <= b; prod_q <= '0; cnt_q <= '0;
            st_q    <= BUSY;
          end else begin
            res_q   <= bus.jal_in ? npc_ext : alu;
            wdata_q <= rs2;
            waddr_q <= bus.waddr_in;
            wen_q   <= bus.wen_in;
            mw_q    <= bus.memWrite_in;
            mr_q    <= bus.memRead_in;
            mtr_q   <= bus.memtoReg_in;
            tk_q    <= tk_d;
            tgt_q   <= tgt_d;
          end
        end
        BUSY: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(DSIZE - 1)) st_q <= DONE;
        end
        DONE: begin
          // Upstream is still held, so ID/EXE still presents the MUL's control.
          res_q   <= prod_q;
          wdata_q <= rs2;
          waddr_q <= bus.waddr_in;
          wen_q   <= bus.wen_in;
          mw_q    <= bus.memWrite_in;
          mr_q    <= bus.memRead_in;
          mtr_q   <= bus.memtoReg_in;
          st_q    <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_result_out    = res_q;
  assign bus.wdata_out         = wdata_q;
  assign bus.waddr_out         = waddr_q;
  assign bus.wen_out           = wen_q;
  assign bus.memWrite_out      = mw_q;
  assign bus.memRead_out       = mr_q;
  assign bus.memtoReg_out      = mtr_q;
  assign bus.branch_taken_out  = tk_q;
  assign bus.branch_target_out = tgt_q;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expected EXE/MEM entries queued at issue, checked on output.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_if #(.DSIZE(16), .ASIZE(4), .ISIZE(16)) bus();
  exe_stage #(.DSIZE(16), .ASIZE(4), .ISIZE(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [15:0] res;
    logic        wen;
    logic [3:0]  waddr;
    logic        mw;
    logic        tk;
    logic [15:0] tgt;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int   n_chk = 0;
  int   n_err = 0;
  int   stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.rdata1_in = '0; bus.rdata2_in = '0; bus.imm_in = '0;
    bus.raddr1_in = '0; bus.raddr2_in = '0; bus.waddr_in = '0; bus.nPC_in = '0;
    bus.opcode_in = 3'b000; bus.alusrc_in = 1'b0; bus.wen_in = 1'b0;
    bus.memWrite_in = 1'b0; bus.memRead_in = 1'b0; bus.memtoReg_in = 1'b0;
    bus.branch_in = 1'b0; bus.jal_in = 1'b0;
    bus.wb_wen = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
  endtask

  task automatic push(input logic [15:0] res, input logic wen, input logic [3:0] wa,
                      input logic mw, input logic tk, input logic [15:0] tgt);
    exp_t e;
    e.res = res; e.wen = wen; e.waddr = wa; e.mw = mw; e.tk = tk; e.tgt = tgt;
    q.push_back(e);
  endtask

  // Advance until the instruction leaves ID/EXE; returns stalled cycles.
  task automatic step(output int n);
    bit s;
    bit done;
    n = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      s = bus.stall_out;
      @(posedge clk);
      #1;
      if (!s) done = 1;
      else n++;
    end
    if (!done) chk("stall_timeout", 1, 0);
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] exp);
    clr();
    bus.opcode_in = op; bus.rdata1_in = x; bus.rdata2_in = y;
    bus.wen_in = 1'b1; bus.waddr_in = 4'd3;
    push(exp, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0);
    step(stalls);
  endtask

  task automatic mul_op(input logic [15:0] x, input logic [15:0] y, input logic src,
                        input logic [15:0] exp);
    clr();
    bus.opcode_in = 3'b101; bus.rdata1_in = x;
    if (src) begin bus.alusrc_in = 1'b1; bus.imm_in = y; end
    else bus.rdata2_in = y;
    bus.wen_in = 1'b1; bus.waddr_in = 4'd4;
    push(exp, 1'b1, 4'd4, 1'b0, 1'b0, 16'h0);
    step(stalls);
    chk("mul_stall_cycles", stalls, 17);
  endtask

  always @(negedge clk) begin
    if (rst && (bus.wen_out || bus.memWrite_out || bus.branch_taken_out)) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        em = q.pop_front();
        chk("alu_result", bus.alu_result_out, em.res);
        chk("wen", bus.wen_out, em.wen);
        chk("waddr", bus.waddr_out, em.waddr);
        chk("memWrite", bus.memWrite_out, em.mw);
        chk("taken", bus.branch_taken_out, em.tk);
        if (em.tk) chk("target", bus.branch_target_out, em.tgt);
      end
    end
  end

  initial begin
    // Reset with live inputs.
    clr();
    bus.rdata1_in = 16'h3; bus.rdata2_in = 16'h4; bus.wen_in = 1'b1; bus.waddr_in = 4'd2;
    bus.memWrite_in = 1'b1; bus.branch_in = 1'b1; bus.jal_in = 1'b1; bus.nPC_in = 16'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.alu_result_out, 0);
    chk("rst_wen", bus.wen_out, 0);
    chk("rst_memWrite", bus.memWrite_out, 0);
    chk("rst_taken", bus.branch_taken_out, 0);
    chk("rst_target", bus.branch_target_out, 0);
    chk("rst_stall", bus.stall_out, 0);

    rst = 1'b1;
    clr();
    bus.rdata1_in = 16'h3; bus.rdata2_in = 16'h4; bus.wen_in = 1'b1; bus.waddr_in = 4'd2;
    push(16'd7, 1'b1, 4'd2, 1'b0, 1'b0, 16'h0);
    step(stalls);

    // Forwarding priority.
    clr();
    bus.rdata1_in = 16'd2; bus.rdata2_in = 16'd3; bus.wen_in = 1'b1; bus.waddr_in = 4'd1;
    push(16'd5, 1'b1, 4'd1, 1'b0, 1'b0, 16'h0);
    step(stalls);
    clr();
    bus.opcode_in = 3'b001; bus.raddr1_in = 4'd1; bus.rdata1_in = 16'h77;
    bus.alusrc_in = 1'b1; bus.imm_in = 16'd1; bus.wen_in = 1'b1; bus.waddr_in = 4'd2;
    bus.wb_wen = 1'b1; bus.wb_waddr = 4'd1; bus.wb_wdata = 16'd9;
    push(16'd4, 1'b1, 4'd2, 1'b0, 1'b0, 16'h0);
    step(stalls);
    bus.opcode_in = 3'b000; bus.raddr1_in = 4'd0; bus.rdata1_in = 16'd5;
    bus.alusrc_in = 1'b0; bus.rdata2_in = 16'd0; bus.waddr_in = 4'd0;
    push(16'd5, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0);
    step(stalls);
    bus.opcode_in = 3'b001; bus.raddr1_in = 4'd1; bus.rdata1_in = 16'h77;
    bus.alusrc_in = 1'b1; bus.imm_in = 16'd1; bus.waddr_in = 4'd2;
    push(16'd8, 1'b1, 4'd2, 1'b0, 1'b0, 16'h0);
    step(stalls);

    // ALU ops, wrap and signed compare.
    alu_op(3'b000, 16'hFFFF, 16'h0001, 16'h0000);
    alu_op(3'b100, 16'h8000, 16'h0001, 16'h0001);
    alu_op(3'b100, 16'h0001, 16'h8000, 16'h0000);
    alu_op(3'b001, 16'h0000, 16'h0001, 16'hFFFF);
    alu_op(3'b010, 16'hF0F0, 16'h3C3C, 16'h3030);
    alu_op(3'b011, 16'h1200, 16'h0034, 16'h1234);
    alu_op(3'b110, 16'hA5A5, 16'hFFFF, 16'h5A5A);
    alu_op(3'b111, 16'h0003, 16'h0014, 16'h0030);

    // Multiply, including back-to-back and immediate operand.
    mul_op(16'h0123, 16'h0010, 1'b0, 16'h1230);
    mul_op(16'h0007, 16'h0009, 1'b0, 16'h003F);
    mul_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0001);
    mul_op(16'h1234, 16'h0100, 1'b1, 16'h3400);

    // BEQ then wrong-path STORE.
    clr();
    bus.opcode_in = 3'b001; bus.rdata1_in = 16'd5; bus.rdata2_in = 16'd5; bus.branch_in = 1'b1;
    bus.nPC_in = 16'h0010; bus.imm_in = 16'hFFFC;
    push(16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 16'h000C);
    step(stalls);
    clr();
    bus.alusrc_in = 1'b1; bus.imm_in = 16'd2; bus.rdata2_in = 16'h55; bus.memWrite_in = 1'b1;
    step(stalls);
    chk("squash_store_memWrite", bus.memWrite_out, 0);
    chk("taken_one_cycle", bus.branch_taken_out, 0);

    // BEQ then wrong-path MUL.
    clr();
    bus.opcode_in = 3'b001; bus.rdata1_in = 16'd9; bus.rdata2_in = 16'd9; bus.branch_in = 1'b1;
    bus.nPC_in = 16'h0010; bus.imm_in = 16'hFFFC;
    push(16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 16'h000C);
    step(stalls);
    clr();
    bus.opcode_in = 3'b101; bus.rdata1_in = 16'd3; bus.rdata2_in = 16'd3;
    bus.wen_in = 1'b1; bus.waddr_in = 4'd6;
    step(stalls);
    chk("squash_mul_stall", stalls, 0);
    chk("squash_mul_wen", bus.wen_out, 0);
    clr();
    step(stalls);

    // JAL.
    clr();
    bus.jal_in = 1'b1; bus.nPC_in = 16'h0020; bus.imm_in = 16'h0004;
    bus.wen_in = 1'b1; bus.waddr_in = 4'd7;
    push(16'h0020, 1'b1, 4'd7, 1'b0, 1'b1, 16'h0024);
    step(stalls);
    clr();
    step(stalls);

    // Reset while multiplying aborts the multiply.
    clr();
    bus.opcode_in = 3'b101; bus.rdata1_in = 16'd3; bus.rdata2_in = 16'd5;
    bus.wen_in = 1'b1; bus.waddr_in = 4'd5;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_stall", bus.stall_out, 1);
    clr();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_stall", bus.stall_out, 0);
    chk("midrst_wen", bus.wen_out, 0);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(stalls);
      if (i == 0) chk("post_rst_stall", stalls, 0);
    end

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
